// File: rtl/game_pkg.sv
// Shared constants for the game sequencer: one-hot state indices, button indices,
// default parameters and a helper that builds a one-hot state vector.
package game_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_DRAW_MAP  = 4'd1,
    S_DRAW_LINK = 4'd2,
    S_IDLE      = 4'd3,
    S_ATTACK    = 4'd4,
    S_UP        = 4'd5,
    S_DOWN      = 4'd6,
    S_LEFT      = 4'd7,
    S_RIGHT     = 4'd8
  } state_e;

  localparam int N_STATES = 9;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_ATTACK = 4;
  localparam int N_BTNS     = 5;

  localparam int          DEFAULT_ATTACK_FRAMES  = 8;
  localparam logic [20:0] DEFAULT_TIMEOUT_CYCLES = 21'd200000;

  function automatic logic [N_STATES-1:0] state_bit(input state_e s);
    state_bit    = '0;
    state_bit[s] = 1'b1;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser bringing the asynchronous push-buttons into the clock domain.
module button_sync
  import game_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BTNS-1:0] raw,
  output logic [N_BTNS-1:0] synced
);

  logic [N_BTNS-1:0] meta;

  // NOTE: non-blocking assignments make both stages sample the old values, giving a true 2-flop chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/game_control.sv
// Frame sequencer: map draw, Link draw, idle wait, then at most one button action per frame.
// Optional draw-state watchdog enabled by defining GAME_CTRL_DRAW_TIMEOUT_EN.
module game_control
  import game_pkg::*;
#(
  parameter int          ATTACK_FRAMES  = DEFAULT_ATTACK_FRAMES,
  parameter logic [20:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_attack,
  input  logic draw_map_done,
  input  logic draw_link_done,
  input  logic idle_done,
  output logic init,
  output logic idle,
  output logic attack,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic draw_map,
  output logic draw_link,
  output logic draw_timeout
);

  localparam logic [7:0] LOCK_RELOAD = 8'(ATTACK_FRAMES - 1);

  logic [N_STATES-1:0] state;
  logic [7:0]          lock_cnt;
  logic [N_BTNS-1:0]   btn_raw;
  logic [N_BTNS-1:0]   btn;
  logic                wd_expire;

  always_comb begin
    btn_raw             = '0;
    btn_raw[BTN_UP]     = btn_up;
    btn_raw[BTN_DOWN]   = btn_down;
    btn_raw[BTN_LEFT]   = btn_left;
    btn_raw[BTN_RIGHT]  = btn_right;
    btn_raw[BTN_ATTACK] = btn_attack;
  end

  button_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .raw    (btn_raw),
    .synced (btn)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= state_bit(S_INIT);
      lock_cnt <= '0;
    end else begin
      if (state[S_INIT]) begin
        state <= state_bit(S_DRAW_MAP);
      end else if (state[S_DRAW_MAP]) begin
        if (draw_map_done || wd_expire) state <= state_bit(S_DRAW_LINK);
      end else if (state[S_DRAW_LINK]) begin
        if (draw_link_done || wd_expire) state <= state_bit(S_IDLE);
      end else if (state[S_IDLE]) begin
        if (idle_done) begin
          // A pending lockout swallows the whole frame, buttons included.
          if (lock_cnt != 8'd0) begin
            lock_cnt <= lock_cnt - 8'd1;
            state    <= state_bit(S_DRAW_MAP);
          end else if (btn[BTN_ATTACK]) begin
            lock_cnt <= LOCK_RELOAD;
            state    <= state_bit(S_ATTACK);
          end else if (btn[BTN_UP]) begin
            state <= state_bit(S_UP);
          end else if (btn[BTN_DOWN]) begin
            state <= state_bit(S_DOWN);
          end else if (btn[BTN_LEFT]) begin
            state <= state_bit(S_LEFT);
          end else if (btn[BTN_RIGHT]) begin
            state <= state_bit(S_RIGHT);
          end else begin
            state <= state_bit(S_DRAW_MAP);
          end
        end
      end else begin
        // Action states last one cycle; an all-zero state also recovers here.
        state <= state_bit(S_DRAW_MAP);
      end
    end
  end

`ifdef GAME_CTRL_DRAW_TIMEOUT_EN
  logic [20:0] wd_cnt;
  logic        in_draw;
  logic        draw_adv;
  logic        timeout_flag;

  assign in_draw   = state[S_DRAW_MAP] | state[S_DRAW_LINK];
  assign wd_expire = in_draw && (wd_cnt == TIMEOUT_CYCLES - 21'd1);
  assign draw_adv  = (state[S_DRAW_MAP]  && (draw_map_done  || wd_expire)) ||
                     (state[S_DRAW_LINK] && (draw_link_done || wd_expire));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      // Clearing on every draw advance restarts the count on entry to the next draw state.
      if (!in_draw || draw_adv) wd_cnt <= '0;
      else                      wd_cnt <= wd_cnt + 21'd1;
      if ((state[S_DRAW_MAP]  && !draw_map_done  && wd_expire) ||
          (state[S_DRAW_LINK] && !draw_link_done && wd_expire))
        timeout_flag <= 1'b1;
    end
  end

  assign draw_timeout = timeout_flag;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expire      = 1'b0;
  assign draw_timeout   = 1'b0;
`endif

  assign init      = state[S_INIT];
  assign draw_map  = state[S_DRAW_MAP];
  assign draw_link = state[S_DRAW_LINK];
  assign idle      = state[S_IDLE];
  assign attack    = state[S_ATTACK];
  assign up        = state[S_UP];
  assign down      = state[S_DOWN];
  assign left      = state[S_LEFT];
  assign right     = state[S_RIGHT];

endmodule

// File: tb/tb_game_control.sv
// Scoreboard bench for game_control: stimulus pushes the hand-derived state per cycle,
// a negedge monitor pops and compares. Watchdog steps run when GAME_CTRL_DRAW_TIMEOUT_EN is defined.
module tb_game_control;

  localparam logic [8:0] E_NONE  = 9'h000;
  localparam logic [8:0] E_INIT  = 9'h001;
  localparam logic [8:0] E_MAP   = 9'h002;
  localparam logic [8:0] E_LINK  = 9'h004;
  localparam logic [8:0] E_IDLE  = 9'h008;
  localparam logic [8:0] E_ATK   = 9'h010;
  localparam logic [8:0] E_UP    = 9'h020;
  localparam logic [8:0] E_DOWN  = 9'h040;
  localparam logic [8:0] E_LEFT  = 9'h080;
  localparam logic [8:0] E_RIGHT = 9'h100;

  typedef struct {
    logic [9:0] val;
    int         id;
  } exp_t;

  logic clock, reset;
  logic btn_up, btn_down, btn_left, btn_right, btn_attack;
  logic draw_map_done, draw_link_done, idle_done;
  logic init, idle, attack, up, down, left, right, draw_map, draw_link, draw_timeout;

  exp_t       sb[$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         step_id = 0;
  logic       exp_to  = 1'b0;
  logic [9:0] mon_act;
  exp_t       mon_e;

  game_control #(.ATTACK_FRAMES(3), .TIMEOUT_CYCLES(21'd16)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_attack     (btn_attack),
    .draw_map_done  (draw_map_done),
    .draw_link_done (draw_link_done),
    .idle_done      (idle_done),
    .init           (init),
    .idle           (idle),
    .attack         (attack),
    .up             (up),
    .down           (down),
    .left           (left),
    .right          (right),
    .draw_map       (draw_map),
    .draw_link      (draw_link),
    .draw_timeout   (draw_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      mon_act = {draw_timeout, right, left, down, up, attack, idle, draw_link, draw_map, init};
      check("onehot", 32'($onehot(mon_act[8:0])), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check($sformatf("step%0d", mon_e.id), 32'(mon_act), 32'(mon_e.val));
      end
    end
  end

  // One clock cycle: drive done inputs, record the state expected in this cycle.
  task automatic cyc(input logic [8:0] exp, input logic md, input logic ld, input logic id);
    draw_map_done  = md;
    draw_link_done = ld;
    idle_done      = id;
    sb.push_back('{val: {exp_to, exp}, id: step_id});
    step_id++;
    @(posedge clock);
    #1;
  endtask

  task automatic frame(input logic [8:0] act);
    cyc(E_MAP,  1'b1, 1'b0, 1'b0);
    cyc(E_LINK, 1'b0, 1'b1, 1'b0);
    cyc(E_IDLE, 1'b0, 1'b0, 1'b1);
    if (act != E_NONE) cyc(act, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_btns(input logic a, input logic u, input logic d, input logic l, input logic r);
    btn_attack = a;
    btn_up     = u;
    btn_down   = d;
    btn_left   = l;
    btn_right  = r;
  endtask

  initial begin
    reset = 1'b1;
    set_btns(0, 0, 0, 0, 0);
    draw_map_done = 0; draw_link_done = 0; idle_done = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset release and a plain frame with waits in each draw state
    cyc(E_INIT, 0, 0, 0);
    cyc(E_MAP,  0, 0, 0);
    cyc(E_MAP,  0, 0, 0);
    cyc(E_MAP,  1, 0, 0);
    cyc(E_LINK, 0, 0, 0);
    cyc(E_LINK, 0, 1, 0);
    cyc(E_IDLE, 0, 0, 0);
    cyc(E_IDLE, 0, 0, 1);

    // Button priority
    set_btns(0, 1, 0, 1, 0); frame(E_UP);
    set_btns(0, 0, 1, 1, 1); frame(E_DOWN);
    set_btns(0, 0, 0, 1, 1); frame(E_LEFT);
    set_btns(0, 0, 0, 0, 1); frame(E_RIGHT);
    set_btns(0, 0, 0, 0, 0); frame(E_NONE);

    // Done inputs outside their own state are ignored and not remembered
    cyc(E_MAP,  0, 0, 1);
    cyc(E_MAP,  0, 1, 0);
    cyc(E_MAP,  1, 0, 0);
    cyc(E_LINK, 0, 0, 1);
    cyc(E_LINK, 0, 1, 0);
    cyc(E_IDLE, 0, 0, 0);
    cyc(E_IDLE, 1, 1, 0);
    cyc(E_IDLE, 0, 0, 1);

    // Attack lockout with ATTACK_FRAMES = 3
    set_btns(1, 1, 0, 0, 0); frame(E_ATK);
    set_btns(1, 0, 1, 0, 0); frame(E_NONE);
    frame(E_NONE);
    frame(E_ATK);
    frame(E_NONE);

    // Asynchronous reset in the middle of DRAW_LINK while lock_cnt is 1
    cyc(E_MAP, 1, 0, 0);
    draw_link_done = 0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_init",      32'(init),         32'd1);
    check("rst_draw_link", 32'(draw_link),    32'd0);
    check("rst_lock_cnt",  32'(dut.lock_cnt), 32'd0);
    draw_map_done = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(E_INIT, 1, 0, 0);
    cyc(E_MAP,  1, 0, 0);
    cyc(E_LINK, 0, 1, 0);
    cyc(E_IDLE, 0, 0, 1);
    cyc(E_ATK,  0, 0, 0);
    set_btns(0, 0, 0, 0, 0);

`ifdef GAME_CTRL_DRAW_TIMEOUT_EN
    // Map draw never finishes: watchdog advances after 16 cycles and latches the flag
    repeat (16) cyc(E_MAP, 0, 0, 0);
    exp_to = 1'b1;
    cyc(E_LINK, 0, 1, 0);
    cyc(E_IDLE, 0, 0, 1);
    cyc(E_MAP,  1, 0, 0);
    cyc(E_LINK, 0, 1, 0);
    cyc(E_IDLE, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("timeout_cleared", 32'(draw_timeout), 32'd0);
    exp_to = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(E_INIT, 0, 0, 0);
    cyc(E_MAP,  1, 0, 0);
`else
    // Without the watchdog a draw state waits indefinitely
    repeat (20) cyc(E_MAP, 0, 0, 0);
    cyc(E_MAP,  1, 0, 0);
    cyc(E_LINK, 0, 1, 0);
    cyc(E_IDLE, 0, 0, 1);
    cyc(E_MAP,  0, 0, 0);
`endif

    @(negedge clock);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
